// File: rtl/mjpeg_fifo_pkg.sv
// Shared helpers for the MJPEG line/coefficient FIFO controllers.
// - lw_of   : width of a level counter able to hold depth + 3 distinct values
//             (0 .. depth+2 words: RAM contents plus the two-entry prefetch buffer)
// - ptr_inc : pointer advance with an explicit wrap at depth-1, so depths that are
//             not a power of two wrap correctly
package mjpeg_fifo_pkg;

    function automatic int lw_of(input int depth);
        return $clog2(depth + 3);
    endfunction

    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
        logic [31:0] nxt;
        if (ptr == depth - 32'd1) begin
            nxt = 32'd0;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rfdp_fifo_pfbuf.sv
// Two-entry prefetch/skid buffer sitting behind the RAM read port.
// Entries leave in the order they arrived. The head entry drives data/valid
// directly from registers.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear; dominates wr_en/rd_en
//   wr_en      : capture wr_data at the end of this cycle
//   wr_data    : RAM read data being returned
//   rd_en      : head entry is consumed this cycle (ignored when empty)
//   valid/data : head entry
//   cnt        : number of entries held (0..2)
module rfdp_fifo_pfbuf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       cnt
);

    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic [1:0]       cnt_r;
    logic             valid_r;
    logic             rd_s;

    // A read of an empty buffer is treated as no read.
    assign rd_s = rd_en & (cnt_r != 2'd0);

    // Entry storage and occupancy; a simultaneous write and read keeps order by
    // moving the tail to the head before the new word lands behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {WIDTH{1'b0}};
            tail_r  <= {WIDTH{1'b0}};
            cnt_r   <= 2'd0;
            valid_r <= 1'b0;
        end else if (flush) begin
            head_r  <= {WIDTH{1'b0}};
            tail_r  <= {WIDTH{1'b0}};
            cnt_r   <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            case ({wr_en, rd_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        head_r <= wr_data;
                    end else begin
                        tail_r <= wr_data;
                    end
                    cnt_r   <= cnt_r + 2'd1;
                    valid_r <= 1'b1;
                end
                2'b01: begin
                    head_r  <= tail_r;
                    cnt_r   <= cnt_r - 2'd1;
                    valid_r <= (cnt_r == 2'd2);
                end
                2'b11: begin
                    if (cnt_r == 2'd2) begin
                        head_r <= tail_r;
                        tail_r <= wr_data;
                    end else begin
                        head_r <= wr_data;
                    end
                    valid_r <= 1'b1;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign valid = valid_r;
    assign data  = head_r;
    assign cnt   = cnt_r;

endmodule

// File: rtl/rfdp_fifo_ctrl.sv
// FIFO controller for an rfdp<DEPTH>x<WIDTH> dual-port RAM macro. Writes go
// through RAM port B, reads through port A. The 1-cycle read latency is hidden
// by a two-entry prefetch buffer so the output is a full-rate valid/ready stream.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : synchronous clear of all contents
//   in_valid/in_data     : upstream stream; in_ready is registered
//   out_valid/out_data   : downstream stream (registered); out_ready accepts
//   level                : words held (RAM + read in flight + prefetch buffer)
//   ram_aa/ram_cena/ram_qa   : RAM read port A (cena active-low)
//   ram_ab/ram_db/ram_cenb   : RAM write port B (cenb active-low)
module rfdp_fifo_ctrl
    import mjpeg_fifo_pkg::*;
#(
    parameter  int DEPTH = 512,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = lw_of(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [LW-1:0]    level,
    output logic [AW-1:0]    ram_aa,
    output logic             ram_cena,
    input  logic [WIDTH-1:0] ram_qa,
    output logic [AW-1:0]    ram_ab,
    output logic [WIDTH-1:0] ram_db,
    output logic             ram_cenb
);

    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    ram_cnt_r;
    logic [LW-1:0]    level_r;
    logic             inflight_r;
    logic             in_ready_r;

    logic             push_s;
    logic             pop_s;
    logic             issue_s;
    logic [2:0]       occ_s;
    logic [LW-1:0]    ram_cnt_next_s;
    logic             buf_valid_s;
    logic [WIDTH-1:0] buf_data_s;
    logic [1:0]       buf_cnt_s;

    assign push_s = in_valid & in_ready_r & ~flush;
    assign pop_s  = buf_valid_s & out_ready;

    // Prefetch occupancy after this cycle's pop; a read is only issued when
    // its return is guaranteed a free buffer slot.
    assign occ_s   = {1'b0, buf_cnt_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    // ram_cnt excludes this cycle's push, so a read never hits the word being written.
    assign issue_s = (ram_cnt_r != {LW{1'b0}}) & (occ_s <= 3'd1) & ~flush;

    assign ram_cnt_next_s = ram_cnt_r + {{(LW-1){1'b0}}, push_s} - {{(LW-1){1'b0}}, issue_s};

    // Pointers, RAM word count, read-in-flight flag, input readiness and level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            ram_cnt_r  <= {LW{1'b0}};
            level_r    <= {LW{1'b0}};
            inflight_r <= 1'b0;
            in_ready_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            ram_cnt_r  <= {LW{1'b0}};
            level_r    <= {LW{1'b0}};
            inflight_r <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= AW'(ptr_inc(32'(wr_ptr_r), 32'(DEPTH)));
            end
            if (issue_s) begin
                rd_ptr_r <= AW'(ptr_inc(32'(rd_ptr_r), 32'(DEPTH)));
            end
            inflight_r <= issue_s;
            ram_cnt_r  <= ram_cnt_next_s;
            in_ready_r <= (ram_cnt_next_s < LW'(DEPTH));
            // Words move between RAM, flight and buffer without changing the total.
            level_r    <= level_r + {{(LW-1){1'b0}}, push_s} - {{(LW-1){1'b0}}, pop_s};
        end
    end

    rfdp_fifo_pfbuf #(
        .WIDTH (WIDTH)
    ) u_pfbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (inflight_r),
        .wr_data (ram_qa),
        .rd_en   (pop_s),
        .valid   (buf_valid_s),
        .data    (buf_data_s),
        .cnt     (buf_cnt_s)
    );

    // Enables are gated by rst_n so the macro is idle the instant reset asserts.
    assign ram_cenb  = ~(push_s & rst_n);
    assign ram_cena  = ~(issue_s & rst_n);
    assign ram_ab    = wr_ptr_r;
    assign ram_aa    = rd_ptr_r;
    assign ram_db    = in_data;

    assign in_ready  = in_ready_r;
    assign out_valid = buf_valid_s;
    assign out_data  = buf_data_s;
    assign level     = level_r;

endmodule

// File: tb/tb_rfdp_fifo_ctrl.sv
// Self-checking bench for rfdp_fifo_ctrl with a behavioural RAM model.
module tb_rfdp_fifo_ctrl;
    localparam int D  = 12;
    localparam int W  = 32;
    localparam int AW = $clog2(D);
    localparam int LW = $clog2(D + 3);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready = 1'b0;
    logic [LW-1:0] level;
    logic [AW-1:0] ram_aa;
    logic          ram_cena;
    logic [W-1:0]  ram_qa;
    logic [AW-1:0] ram_ab;
    logic [W-1:0]  ram_db;
    logic          ram_cenb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rfdp_fifo_ctrl #(.DEPTH(D), .WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level),
        .ram_aa(ram_aa), .ram_cena(ram_cena), .ram_qa(ram_qa),
        .ram_ab(ram_ab), .ram_db(ram_db), .ram_cenb(ram_cenb)
    );

    // RAM macro model: synchronous write, 1-cycle registered read
    logic [W-1:0] mem [D];
    always @(posedge clk) begin
        if (!ram_cenb) mem[ram_ab] <= ram_db;
        if (!ram_cena) ram_qa <= mem[ram_aa];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Prefetch buffer must never exceed its two entries
    always @(negedge clk) begin
        if (rst_n) check("pfbuf_overflow", 64'(u_dut.buf_cnt_s <= 2'd2), 64'd1);
    end

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_ir;
        int          e_lvl;
        logic        e_cenb;
    } vec_t;

    vec_t vt [15];
    logic [31:0] q [$];
    int acc, sent, got;

    initial begin
        // iv, id, ordy, fl | expected before this cycle's edge: ov, od, ir, level ; cenb during cycle
        vt[0]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 0, 1'b1};
        vt[1]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 0, 1'b0};
        vt[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1, 1'b1};
        vt[3]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1, 1'b1};
        vt[4]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 1, 1'b1};
        vt[5]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 1, 1'b1};
        vt[6]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 0, 1'b1};
        vt[7]  = '{1'b1, 32'hDEAD_0007, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 0, 1'b1};
        vt[8]  = '{1'b1, 32'hB000_0001, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 0, 1'b0};
        vt[9]  = '{1'b1, 32'hB000_0002, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1, 1'b0};
        vt[10] = '{1'b1, 32'hB000_0003, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 2, 1'b0};
        vt[11] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hB000_0001, 1'b1, 3, 1'b1};
        vt[12] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hB000_0002, 1'b1, 2, 1'b1};
        vt[13] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hB000_0003, 1'b1, 1, 1'b1};
        vt[14] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_level", level, 0);
        check("rst_cena", ram_cena, 1);
        check("rst_cenb", ram_cenb, 1);
        rst_n = 1'b1;

        // Table: latency, flush-with-push, short burst
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("vec_out_valid", out_valid, vt[i].e_ov);
            if (vt[i].e_ov) check("vec_out_data", out_data, vt[i].e_od);
            check("vec_in_ready", in_ready, vt[i].e_ir);
            check("vec_level", level, 64'(vt[i].e_lvl));
            in_valid  = vt[i].iv;
            in_data   = vt[i].id;
            out_ready = vt[i].ordy;
            flush     = vt[i].fl;
            #1;
            check("vec_cenb", ram_cenb, vt[i].e_cenb);
        end

        // Fill with downstream stalled
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
            in_data = 32'h100 + acc;
            if (in_ready) acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("fill_accepted", acc, D + 2);
        check("fill_in_ready", in_ready, 0);
        check("fill_level", level, D + 2);
        check("fill_out_valid", out_valid, 1);

        // Drain in order, one word per cycle
        out_ready = 1'b1;
        for (int k = 0; k < D + 2; k++) begin
            check("drain_valid", out_valid, 1);
            check("drain_data", out_data, 32'h100 + k);
            if (k == 0) check("drain_ready_first", in_ready, 0);
            if (k == 1) check("drain_ready_back", in_ready, 1);
            @(negedge clk);
        end
        check("drain_empty", out_valid, 0);
        check("drain_level", level, 0);

        // Random traffic across many pointer wraps
        sent = 0; got = 0;
        for (int c = 0; c < 3000 && got < 100; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 100) && ($urandom_range(0, 2) != 0);
            in_data   = 32'hC000_0000 + sent;
            if (out_valid && out_ready) begin
                check("wrap_underrun", 64'(q.size() != 0), 1);
                if (q.size() != 0) check("wrap_data", out_data, q.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                sent++;
            end
            #1;
            if (!ram_cenb) check("wrap_ab_range", 64'(ram_ab < AW'(D)), 1);
            if (!ram_cena) check("wrap_aa_range", 64'(ram_aa < AW'(D)), 1);
            @(negedge clk);
        end
        check("wrap_count", got, 100);
        in_valid = 1'b0;

        // Streaming: one word per cycle after 3-cycle fill
        @(negedge clk);
        check("stream_start_level", level, 0);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            in_data = 32'h5000_0000 + c;
            check("stream_in_ready", in_ready, 1);
            if (c >= 3) begin
                check("stream_valid", out_valid, 1);
                check("stream_data", out_data, 32'h5000_0000 + c - 3);
                check("stream_level", level, 3);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("stream_drained", level, 0);

        // Flush with concurrent push and read return
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hF000_0001;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_inflight", u_dut.inflight_r, 1);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hF000_0002;
        #1;
        check("flush_cenb", ram_cenb, 1);
        check("flush_cena", ram_cena, 1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush_level", level, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("flush_no_output", out_valid, 0);
        end

        // Asynchronous reset mid-stream
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_data = 32'h7000_0000 + c;
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cena", ram_cena, 1);
        check("arst_cenb", ram_cenb, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_level", level, 0);
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("arst_ready_held", in_ready, 0);
        @(negedge clk);
        check("arst_ready_rise", in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
